// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned steps(input int unsigned width, input int unsigned digit);
      return width / digit;
   endfunction

   function automatic bit width_ok(input int unsigned width, input int unsigned digit);
      return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
   endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational ripple chain of DIGIT full-adder cells; c_msb_in is the carry into the top cell.
module digit_adder #(
   parameter int unsigned DIGIT = 2
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             c_in,
   output logic [DIGIT-1:0] s_d,
   output logic             c_out,
   output logic             c_msb_in
);

   logic [DIGIT:0] c;

   always_comb begin
      c    = '0;
      s_d  = '0;
      c[0] = c_in;
      for (int i = 0; i < int'(DIGIT); i++) begin
         s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
         c[i + 1] = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
      end
   end

   assign c_out    = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: DIGIT bits per cycle with valid/ready handshakes.
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned STEPS = steps(WIDTH, DIGIT);
   localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   if (!width_ok(WIDTH, DIGIT)) begin : g_param_check
      $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
   end

   state_t             state_q;
   logic [WIDTH-1:0]   a_q, b_q, sh_q;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt_q;

   logic [DIGIT-1:0]   s_dig;
   logic               c_dig;
   logic               c_msb;
   logic [WIDTH+DIGIT-1:0] sh_cat;
   logic [WIDTH-1:0]   sh_d, a_d, b_d;
   logic               last_step;

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .a_d      (a_q[DIGIT-1:0]),
      .b_d      (b_q[DIGIT-1:0]),
      .c_in     (carry_q),
      .s_d      (s_dig),
      .c_out    (c_dig),
      .c_msb_in (c_msb)
   );

   // New digit enters at the top so the LSB digit ends up at bit 0 after STEPS shifts.
   assign sh_cat    = {s_dig, sh_q};
   assign sh_d      = sh_cat[WIDTH+DIGIT-1:DIGIT];
   assign a_d       = a_q >> DIGIT;
   assign b_d       = b_q >> DIGIT;
   assign last_step = (cnt_q == CNT_W'(STEPS - 1));

`ifndef SERIAL_ADDER_OVF_EN
   logic unused_c_msb;
   assign unused_c_msb = c_msb;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sh_q      <= '0;
         carry_q   <= 1'b0;
         cnt_q     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= b;
                  sh_q     <= '0;
                  carry_q  <= cin;
                  cnt_q    <= '0;
                  state_q  <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               a_q     <= a_d;
               b_q     <= b_d;
               sh_q    <= sh_d;
               carry_q <= c_dig;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_step) begin
                  sum       <= sh_d;
                  cout      <= c_dig;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf       <= c_msb ^ c_dig;
`endif
                  state_q   <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q   <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
